// File: rtl/grant_burst_controller.sv
// Purpose: latches a one-hot arbiter grant as bus owner and drives a
//          BURST_LEN-beat burst from that owner's data onto a valid/ready bus.
// Latency: grant seen at edge n -> bus_valid visible in cycle n+1; done pulse
//          the cycle after the last transfer; holds on bus_ready=0 with no timeout.
// Ports:   clk, rst (sync, active-high); gnt_0..2 and data_0..2 from requesters;
//          bus_ready in; bus_valid/bus_data/bus_owner/busy/done_0..2/grant_err out.
module grant_burst_controller #(
   parameter int DATA_W    = 8,
   parameter int BURST_LEN = 4,
   parameter int CNT_W     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              gnt_0,
   input  logic              gnt_1,
   input  logic              gnt_2,
   input  logic [DATA_W-1:0] data_0,
   input  logic [DATA_W-1:0] data_1,
   input  logic [DATA_W-1:0] data_2,
   input  logic              bus_ready,
   output logic              bus_valid,
   output logic [DATA_W-1:0] bus_data,
   output logic [1:0]        bus_owner,
   output logic              busy,
   output logic              done_0,
   output logic              done_1,
   output logic              done_2,
   output logic              grant_err
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [1:0]       OWNER_NONE = 2'd3;
   localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BURST_LEN - 1);

   state_t           state_q, state_d;
   logic [1:0]       owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       done_q, done_d;
   logic             err_q, err_d;
   logic             valid_q, busy_q;
   logic             multi_gnt;

   // Two or more grants at once can only come from a broken upstream arbiter.
   assign multi_gnt = (gnt_0 & gnt_1) | (gnt_0 & gnt_2) | (gnt_1 & gnt_2);

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      cnt_d   = cnt_q;
      done_d  = 3'b000;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            owner_d = OWNER_NONE;
            // Lowest index wins if the arbiter ever hands out several grants.
            if (gnt_0 | gnt_1 | gnt_2) begin
               state_d = BURST;
               cnt_d   = '0;
               err_d   = multi_gnt;
               if (gnt_0)      owner_d = 2'd0;
               else if (gnt_1) owner_d = 2'd1;
               else            owner_d = 2'd2;
            end
         end
         BURST: begin
            // Grants are deliberately ignored here; only bus_ready matters.
            if (bus_ready) begin
               if (cnt_q == LAST_BEAT) begin
                  state_d = DONE;
                  case (owner_q)
                     2'd0:    done_d = 3'b001;
                     2'd1:    done_d = 3'b010;
                     2'd2:    done_d = 3'b100;
                     default: done_d = 3'b000;
                  endcase
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
         end
         DONE: begin
            state_d = IDLE;
            owner_d = OWNER_NONE;
         end
         default: begin
            state_d = IDLE;
            owner_d = OWNER_NONE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= OWNER_NONE;
         cnt_q   <= '0;
         done_q  <= 3'b000;
         err_q   <= 1'b0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         cnt_q   <= cnt_d;
         done_q  <= done_d;
         err_q   <= err_d;
         valid_q <= (state_d == BURST);
         busy_q  <= (state_d != IDLE);
      end
   end

   // Data is muxed live from the requester selected by the registered owner.
   always_comb begin
      bus_data = '0;
      if (valid_q) begin
         case (owner_q)
            2'd0:    bus_data = data_0;
            2'd1:    bus_data = data_1;
            2'd2:    bus_data = data_2;
            default: bus_data = '0;
         endcase
      end
   end

   assign bus_valid = valid_q;
   assign bus_owner = owner_q;
   assign busy      = busy_q;
   assign done_0    = done_q[0];
   assign done_1    = done_q[1];
   assign done_2    = done_q[2];
   assign grant_err = err_q;

endmodule

// File: tb/tb_grant_burst_controller.sv
module tb_grant_burst_controller;

   localparam int DATA_W = 8;
   localparam int BL     = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              gnt_0, gnt_1, gnt_2;
   logic [DATA_W-1:0] data_0, data_1, data_2;
   logic              bus_ready;
   logic              bus_valid;
   logic [DATA_W-1:0] bus_data;
   logic [1:0]        bus_owner;
   logic              busy;
   logic              done_0, done_1, done_2;
   logic              grant_err;

   int n_checks = 0;
   int n_fail   = 0;
   int n_xfer   = 0;

   // Reference model: who owns the bus and how many beats have gone by.
   bit m_active = 1'b0;
   int m_owner  = 3;
   int m_beats  = 0;
   bit m_err    = 1'b0;

   grant_burst_controller #(.DATA_W(DATA_W), .BURST_LEN(BL), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .gnt_0(gnt_0), .gnt_1(gnt_1), .gnt_2(gnt_2),
      .data_0(data_0), .data_1(data_1), .data_2(data_2),
      .bus_ready(bus_ready), .bus_valid(bus_valid), .bus_data(bus_data),
      .bus_owner(bus_owner), .busy(busy),
      .done_0(done_0), .done_1(done_1), .done_2(done_2),
      .grant_err(grant_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      int ng;
      ng = int'(gnt_0) + int'(gnt_1) + int'(gnt_2);
      if (rst) begin
         m_active = 1'b0;
         m_owner  = 3;
         m_beats  = 0;
         m_err    = 1'b0;
      end else if (!m_active) begin
         m_err = (ng > 1);
         if (ng > 0) begin
            m_active = 1'b1;
            m_beats  = 0;
            m_owner  = gnt_0 ? 0 : (gnt_1 ? 1 : 2);
         end
      end else begin
         m_err = 1'b0;
         if (m_beats < BL) begin
            if (bus_ready) m_beats++;
         end else begin
            m_active = 1'b0;
            m_owner  = 3;
         end
      end
   endtask

   // One clock: count a transfer if one is about to happen, advance model, settle.
   task automatic step();
      if (bus_valid === 1'b1 && bus_ready === 1'b1) n_xfer++;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic check_model();
      logic        v_e;
      logic [2:0]  d_e;
      logic [7:0]  dat_e;
      v_e   = m_active && (m_beats < BL);
      d_e   = (m_active && m_beats == BL) ? (3'b001 << m_owner) : 3'b000;
      dat_e = !v_e ? 8'h00 : (m_owner == 0 ? data_0 : (m_owner == 1 ? data_1 : data_2));
      check("valid", {31'd0, bus_valid}, {31'd0, v_e});
      check("owner", {30'd0, bus_owner}, m_active ? m_owner : 3);
      check("busy", {31'd0, busy}, {31'd0, m_active});
      check("done", {29'd0, done_2, done_1, done_0}, {29'd0, d_e});
      check("grant_err", {31'd0, grant_err}, {31'd0, m_err});
      check("data", {24'd0, bus_data}, {24'd0, dat_e});
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         step();
         check_model();
      end
   endtask

   typedef struct {
      logic       rst;
      logic [2:0] gnt;
      logic       rdy;
      logic [7:0] d1;
      logic       v;
      logic [1:0] own;
      logic       bsy;
      logic [2:0] dn;
      logic       err;
      logic [7:0] dat;
   } vec_t;

   vec_t tbl[11];

   initial begin
      bit seen_done;
      logic [1:0] bp [7];
      rst = 1'b1; gnt_0 = 0; gnt_1 = 0; gnt_2 = 0;
      data_0 = 8'h11; data_1 = 8'hA5; data_2 = 8'h22; bus_ready = 1'b1;

      //           rst gnt    rdy d1     v own  bsy dn     err dat
      tbl[0]  = '{1'b1, 3'b000, 1'b1, 8'hA5, 1'b0, 2'd3, 1'b0, 3'b000, 1'b0, 8'h00};
      tbl[1]  = '{1'b1, 3'b000, 1'b1, 8'hA5, 1'b0, 2'd3, 1'b0, 3'b000, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 3'b010, 1'b1, 8'hA5, 1'b1, 2'd1, 1'b1, 3'b000, 1'b0, 8'hA5};
      tbl[3]  = '{1'b0, 3'b000, 1'b1, 8'hA5, 1'b1, 2'd1, 1'b1, 3'b000, 1'b0, 8'hA5};
      tbl[4]  = '{1'b0, 3'b000, 1'b1, 8'hA5, 1'b1, 2'd1, 1'b1, 3'b000, 1'b0, 8'hA5};
      tbl[5]  = '{1'b0, 3'b000, 1'b1, 8'hA5, 1'b1, 2'd1, 1'b1, 3'b000, 1'b0, 8'hA5};
      tbl[6]  = '{1'b0, 3'b000, 1'b1, 8'hA5, 1'b0, 2'd1, 1'b1, 3'b010, 1'b0, 8'h00};
      tbl[7]  = '{1'b0, 3'b000, 1'b1, 8'hA5, 1'b0, 2'd3, 1'b0, 3'b000, 1'b0, 8'h00};
      tbl[8]  = '{1'b0, 3'b110, 1'b0, 8'h5A, 1'b1, 2'd1, 1'b1, 3'b000, 1'b1, 8'h5A};
      tbl[9]  = '{1'b0, 3'b000, 1'b0, 8'h5A, 1'b1, 2'd1, 1'b1, 3'b000, 1'b0, 8'h5A};
      tbl[10] = '{1'b1, 3'b000, 1'b0, 8'h5A, 1'b0, 2'd3, 1'b0, 3'b000, 1'b0, 8'h00};

      for (int i = 0; i < 11; i++) begin
         rst = tbl[i].rst;
         {gnt_2, gnt_1, gnt_0} = tbl[i].gnt;
         bus_ready = tbl[i].rdy;
         data_1 = tbl[i].d1;
         step();
         check($sformatf("tbl%0d.valid", i), {31'd0, bus_valid}, {31'd0, tbl[i].v});
         check($sformatf("tbl%0d.owner", i), {30'd0, bus_owner}, {30'd0, tbl[i].own});
         check($sformatf("tbl%0d.busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
         check($sformatf("tbl%0d.done", i), {29'd0, done_2, done_1, done_0}, {29'd0, tbl[i].dn});
         check($sformatf("tbl%0d.err", i), {31'd0, grant_err}, {31'd0, tbl[i].err});
         check($sformatf("tbl%0d.data", i), {24'd0, bus_data}, {24'd0, tbl[i].dat});
      end
      rst = 1'b0;
      run(1);

      // Backpressure on a requester-0 burst.
      bp = '{2'd1, 2'd0, 2'd0, 2'd1, 2'd1, 2'd0, 2'd1};
      gnt_0 = 1'b1; bus_ready = 1'b1;
      run(1);
      gnt_0 = 1'b0;
      n_xfer = 0;
      for (int i = 0; i < 7; i++) begin
         bus_ready = bp[i][0];
         run(1);
      end
      check("bp.xfers", n_xfer, 4);
      check("bp.done_0", {31'd0, done_0}, 1);
      bus_ready = 1'b1;
      run(1);

      // Grant switches mid-burst; owner must stay 2.
      gnt_2 = 1'b1;
      run(1);
      gnt_2 = 1'b0; gnt_0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         run(1);
         check("chg.owner", {30'd0, bus_owner}, 2);
      end
      run(1);
      check("chg.done_2", {31'd0, done_2}, 1);
      run(1);
      check("chg.gap_idle", {31'd0, busy}, 0);
      run(1);
      check("chg.next_owner", {30'd0, bus_owner}, 0);
      check("chg.next_valid", {31'd0, bus_valid}, 1);
      gnt_0 = 1'b0;
      run(BL + 1);

      // Reset after two beats, then a fresh full burst.
      gnt_1 = 1'b1;
      run(1);
      gnt_1 = 1'b0;
      run(2);
      rst = 1'b1;
      run(1);
      check("rst.valid", {31'd0, bus_valid}, 0);
      check("rst.owner", {30'd0, bus_owner}, 3);
      check("rst.done", {29'd0, done_2, done_1, done_0}, 0);
      rst = 1'b0;
      gnt_2 = 1'b1;
      run(1);
      gnt_2 = 1'b0;
      n_xfer = 0;
      seen_done = 1'b0;
      for (int i = 0; i < BL + 1; i++) begin
         run(1);
         if (done_2) seen_done = 1'b1;
      end
      check("rst.fresh_xfers", n_xfer, BL);
      check("rst.fresh_done", {31'd0, seen_done}, 1);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         {gnt_2, gnt_1, gnt_0} = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
         bus_ready = ($urandom_range(0, 3) != 0);
         data_0 = 8'($urandom);
         data_1 = 8'($urandom);
         data_2 = 8'($urandom);
         run(1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
